// File: rtl/fetch_unit_pkg.sv
// Shared fetch/PC-select definitions: FSM state encoding and opcode constants.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } fu_state_e;

   // Opcodes decoded from instr[15:12]
   localparam logic [3:0] OP_B   = 4'hC;
   localparam logic [3:0] OP_BR  = 4'hD;
   localparam logic [3:0] OP_PCS = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [15:0] PC_STEP = 16'd2;

endpackage

// File: rtl/fetch_unit_add_16b.sv
// Existing 16-bit adder, reused here as the pc+2 incrementer (wraps mod 2^16).
module add_16b (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives instruction memory, fills IF/ID, absorbs one
// stalled ack in a skid entry, halts on HLT_OP and restarts on redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [3:0]  HLT_OP   = OP_HLT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic        ifid_valid,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc,
   output logic        halted
);

   fu_state_e   state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [15:0] ifid_instr_q, ifid_instr_d;
   logic [15:0] ifid_pc_q, ifid_pc_d;
   logic [15:0] skid_q, skid_d;
   logic [15:0] pc_inc;
   logic        take;
   logic [15:0] take_word;

   add_16b u_pc_inc (
      .a   (pc_q),
      .b   (PC_STEP),
      .sum (pc_inc)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      skid_d       = skid_q;
      take         = 1'b0;
      take_word    = imem_rdata;

      if (state_q != ST_BOOT && redirect) begin
         // Flush: drop skid and any same-cycle ack, restart at the aligned target
         pc_d         = redirect_pc & 16'hFFFE;
         ifid_valid_d = 1'b0;
         skid_d       = '0;
         state_d      = ST_FETCH;
      end else begin
         unique case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
               if (imem_ack) begin
                  if (stall) begin
                     skid_d  = imem_rdata;
                     state_d = ST_HOLD;
                  end else begin
                     take = 1'b1;
                  end
               end else if (!stall) begin
                  ifid_valid_d = 1'b0;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  take      = 1'b1;
                  take_word = skid_q;
                  skid_d    = '0;
               end
            end
            ST_HALT: begin
               if (!stall) ifid_valid_d = 1'b0;
            end
            default: state_d = ST_BOOT;
         endcase

         if (take) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = take_word;
            ifid_pc_d    = pc_q;
            if (take_word[15:12] == HLT_OP) begin
               state_d = ST_HALT;
            end else begin
               pc_d    = pc_inc;
               state_d = ST_FETCH;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC & 16'hFFFE;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         skid_q       <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         skid_q       <= skid_d;
      end
   end

   assign imem_req   = (state_q == ST_FETCH);
   assign imem_addr  = pc_q;
   assign ifid_valid = ifid_valid_q;
   assign ifid_instr = ifid_instr_q;
   assign ifid_pc    = ifid_pc_q;
   assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a behavioural fetch model predicts the
// visible outputs each cycle; a monitor compares them on the falling edge.
module tb_fetch_unit;

   localparam bit N = 1'b0;
   localparam bit Y = 1'b1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic        ifid_valid;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc;
   logic        halted;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(16'h0000), .HLT_OP(4'hF)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .ifid_valid  (ifid_valid),
      .ifid_instr  (ifid_instr),
      .ifid_pc     (ifid_pc),
      .halted      (halted)
   );

   logic [15:0] mem [0:255];

   // Behavioural model: where the program counter is, what IF/ID shows,
   // whether a word is parked waiting for decode, and whether we are halted.
   bit          m_boot, m_halt, m_pend, m_v;
   logic [15:0] m_pend_w, m_pc, m_instr, m_ipc;

   logic [50:0] exp_q [$];
   string       tag_q [$];
   string       phase = "init";
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   function automatic logic [50:0] snap_model();
      return {~m_boot & ~m_halt & ~m_pend, m_pc, m_v, m_instr, m_ipc, m_halt};
   endfunction

   function automatic logic [50:0] snap_dut();
      return {imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc, halted};
   endfunction

   task automatic check(input string name, input logic [50:0] act, input logic [50:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got req=%0b addr=%h v=%0b instr=%h ipc=%h halt=%0b, expected req=%0b addr=%h v=%0b instr=%h ipc=%h halt=%0b",
                  name, $time, act[50], act[49:34], act[33], act[32:17], act[16:1], act[0],
                  exp[50], exp[49:34], exp[33], exp[32:17], exp[16:1], exp[0]);
      end
   endtask

   function automatic void model_reset();
      m_boot = 1; m_halt = 0; m_pend = 0; m_v = 0;
      m_pend_w = '0; m_pc = 16'h0000; m_instr = '0; m_ipc = '0;
   endfunction

   function automatic void deliver(input logic [15:0] w);
      m_v = 1; m_instr = w; m_ipc = m_pc;
      if (w[15:12] == 4'hF) m_halt = 1;
      else m_pc = m_pc + 16'd2;
   endfunction

   function automatic void model_step(input bit s, input bit r, input logic [15:0] rpc,
                                      input bit a, input logic [15:0] rd);
      if (m_boot) begin
         m_boot = 0;
      end else if (r) begin
         m_pc = {rpc[15:1], 1'b0}; m_v = 0; m_pend = 0; m_halt = 0;
      end else if (m_halt) begin
         if (!s) m_v = 0;
      end else if (m_pend) begin
         if (!s) begin m_pend = 0; deliver(m_pend_w); end
      end else if (a) begin
         if (s) begin m_pend = 1; m_pend_w = rd; end
         else deliver(rd);
      end else if (!s) begin
         m_v = 0;
      end
   endfunction

   // Called just after a falling edge; returns just after the next one.
   task automatic step(input bit s, input bit r, input logic [15:0] rpc, input bit a);
      logic [15:0] rd;
      rd = mem[m_pc[8:1]];
      stall = s; redirect = r; redirect_pc = rpc; imem_ack = a; imem_rdata = rd;
      model_step(s, r, rpc, a, rd);
      @(posedge clk); #1;
      exp_q.push_back(snap_model());
      tag_q.push_back(phase);
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      #1 check({phase, "_async"}, snap_dut(), 51'd0);
      model_reset();
      imem_ack = 1'b1; stall = 1'b0; redirect = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(snap_model());
      tag_q.push_back(phase);
      @(negedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) check(tag_q.pop_front(), snap_dut(), exp_q.pop_front());
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      model_reset();
      @(negedge clk); #1;
      phase = "reset"; do_reset();

      phase = "seq_fetch";
      repeat (3) step(N, N, 16'h0, Y);
      phase = "stall_hold";
      repeat (3) step(Y, N, 16'h0, Y);
      phase = "stall_release";
      repeat (2) step(N, N, 16'h0, Y);

      phase = "redirect_ack";
      step(N, Y, 16'h0101, Y);
      repeat (2) step(N, N, 16'h0, Y);

      phase = "halt";
      mem[8] = 16'hF000;
      step(N, Y, 16'h0010, N);
      step(N, N, 16'h0, Y);
      step(N, N, 16'h0, Y);
      step(Y, N, 16'h0, Y);
      step(N, N, 16'h0, N);
      phase = "halt_resume";
      step(Y, Y, 16'h0020, Y);
      repeat (3) step(N, N, 16'h0, Y);

      phase = "wrap";
      mem[255] = 16'h10FF;
      step(N, Y, 16'hFFFE, N);
      repeat (2) step(N, N, 16'h0, Y);

      phase = "reset_hold";
      step(N, N, 16'h0, Y);
      repeat (2) step(Y, N, 16'h0, Y);
      do_reset();
      repeat (3) step(N, N, 16'h0, Y);

      phase = "reset_halt";
      step(N, Y, 16'h0010, N);
      step(N, N, 16'h0, Y);
      step(Y, N, 16'h0, N);
      do_reset();
      repeat (2) step(N, N, 16'h0, Y);

      phase = "random";
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            step(bit'($urandom_range(0, 9) < 3), bit'($urandom_range(0, 24) == 0),
                 16'($urandom), bit'($urandom_range(0, 9) < 7));
         end
      end

      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the first fetch address after reset.
REQ-002 Parameter HLT_OP, default 4'hF, is the halt opcode compared against instr[15:12].
REQ-003 Port clk, input, 1, is the single rising-edge clock.
REQ-004 Port rst_n, input, 1, is the asynchronous active-low reset.
REQ-005 Port stall, input, 1: decode is not accepting; hold IF/ID.
REQ-006 Port redirect, input, 1: a taken branch is resolved downstream (the PC-select stage's Branch).
REQ-007 Port redirect_pc, input, 16, is the branch target (the PC-select stage's PC_out).
REQ-008 Port imem_req, output, 1, is the instruction-memory request.
REQ-009 Port imem_addr, output, 16, is the fetch address and always equals pc.
REQ-010 Port imem_ack, input, 1: imem_rdata is valid for imem_addr in this same cycle.
REQ-011 Port imem_rdata, input, 16, is the instruction word.
REQ-012 Port ifid_valid, output, 1: the IF/ID register holds a live instruction.
REQ-013 Port ifid_instr, output, 16, is the IF/ID instruction.
REQ-014 Port ifid_pc, output, 16, is the IF/ID instruction address (the PC-select stage's PC_in).
REQ-015 Port halted, output, 1: the unit is in HALT.

Function
REQ-016 The FSM SHALL have states BOOT, FETCH, HOLD and HALT.
REQ-017 imem_req SHALL equal (state==FETCH), independent of stall.
REQ-018 BOOT SHALL go to FETCH unconditionally after one cycle.
REQ-019 In FETCH, if imem_ack=1 and stall=0, the unit SHALL load IF/ID with {valid=1, imem_rdata, pc}.
REQ-020 In FETCH, if imem_ack=1 and stall=0, pc SHALL become pc+2 unless rdata[15:12]==HLT_OP, in which case pc holds and state goes to HALT.
REQ-021 In FETCH, if imem_ack=1 and stall=1, the unit SHALL capture rdata into a one-entry skid buffer, hold pc and IF/ID, and go to HOLD.
REQ-022 In HOLD, imem_req SHALL be 0; when stall=0, the skid entry SHALL move into IF/ID, pc SHALL update per REQ-020, and state SHALL go to FETCH (or HALT for HLT_OP).
REQ-023 In FETCH with imem_ack=0, pc SHALL hold; IF/ID SHALL get ifid_valid=0 if stall=0, else hold.
REQ-024 In HALT, pc and IF/ID contents SHALL hold, ifid_valid SHALL clear on the first cycle stall=0, and halted SHALL be 1.
REQ-025 redirect=1 SHALL take priority in every state except BOOT.
REQ-026 On redirect, pc SHALL take {redirect_pc[15:1],1'b0}, ifid_valid SHALL clear (flush, regardless of stall), the skid entry and any same-cycle ack SHALL be discarded, and state SHALL go to FETCH.
REQ-027 pc+2 SHALL wrap modulo 2^16 (16'hFFFE -> 16'h0000); pc[0] SHALL always be 0.
REQ-028 Fetch-to-IF/ID latency SHALL be one cycle (ack in cycle n -> ifid_valid in cycle n+1).

Reset
REQ-029 While rst_n=0, outputs SHALL be: state=BOOT, pc=RESET_PC, imem_req=0, ifid_valid=0, ifid_instr=0, ifid_pc=0, halted=0, skid empty.
REQ-030 Reset asserted mid-HOLD or mid-HALT SHALL discard all state immediately, without waiting for a clock.

Structure
REQ-031 A shared package/header SHALL hold the state encoding and opcode constants (B, BR, PCS, HLT), reused by the PC-select stage.
REQ-032 The pc+2 incrementer SHALL instantiate the existing add_16b; no other sub-module is used.

Verification
REQ-033 Reset release with imem_ack tied to 1 and rdata=16'h1000,16'h1001,... -> imem_req=0 in the first cycle; then ifid_pc=0,2,4 on consecutive cycles.
REQ-034 Stall held for 3 cycles while ack=1 at pc=16'h0004 -> state HOLD, imem_req=0, IF/ID unchanged; after release ifid_pc=16'h0004, then pc=16'h0006.
REQ-035 redirect=1 with redirect_pc=16'h0101 in the same cycle as an ack -> ack discarded, ifid_valid=0, next imem_addr=16'h0100.
REQ-036 rdata=16'hF000 at pc=16'h0010 -> ifid_instr=16'hF000, halted=1, pc stays 16'h0010, ifid_valid=0 on the next cycle; a later redirect to 16'h0020 resumes fetch there.
REQ-037 pc=16'hFFFE with ack -> next imem_addr=16'h0000.
REQ-038 rst_n pulsed low mid-HOLD -> all outputs at reset values asynchronously; skid contents never reach IF/ID.
